io_bus_arbiter: RTL

Two-port arbiter and sequencer for the pipeline's memory-mapped IO register block (key inputs, seven-segment display registers). It sits between the CPU MEM stage (port 0) and a debug/monitor master (port 1) on one side, and the single IO register port on the other. It grants one master at a time using round-robin priority. Each transaction runs as a fixed three-phase sequence: latch, access, respond.

---
 rtl/io_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter in front of the IO register
// block. Each granted transaction runs latch -> access -> respond.
// Handshake: a master raises req with we/addr/wdata stable and holds them
// until it sees a one-cycle gnt; a one-cycle ack follows in the next cycle
// carrying rdata. Requests are not queued; a req still high after ack is
// simply a new request.
module io_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_datain,
  output logic              io_we,
  input  logic [DATA_W-1:0] io_dataout,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              rr_last_q, rr_last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

  // State and latched-transaction registers; reset aborts any transaction.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next state: arbitrate and latch in IDLE, capture read data in ACCESS,
  // record the served port in RESP.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    // On a tie the port not served last wins; otherwise the lone requester.
    win       = (m0_req && m1_req) ? ~rr_last_q : m1_req;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d   = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : io_dataout;
        state_d = RESP;
      end
      RESP: begin
        rr_last_d = sel_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state and the latched transaction.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    io_addr   = '0;
    io_datain = '0;
    io_we     = 1'b0;
    case (state_q)
      ACCESS: begin
        m0_gnt    = ~sel_q;
        m1_gnt    = sel_q;
        io_addr   = addr_q;
        io_datain = wdata_q;
        io_we     = we_q;
      end
      RESP: begin
        m0_ack    = ~sel_q;
        m1_ack    = sel_q;
        io_addr   = addr_q;
        io_datain = wdata_q;
      end
      default: ;
    endcase
  end

  assign m0_rdata    = rdata_q;
  assign m1_rdata    = rdata_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
